// File: rtl/omp_pkg.sv
// Shared parameters and state encoding for the OMP b-vector datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package omp_pkg;

  localparam int DATA_W  = 24;  // Q11.13 sample width
  localparam int Q_FRAC  = 13;  // fractional bits
  localparam int LANES   = 4;   // samples per BRAM word
  localparam int N_WORDS = 16;  // words per Q column / y vector
  localparam int K_MAX   = 16;  // maximum number of b entries
  localparam int ACC_W   = 48;  // accumulator width

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/calc_b_vector_if.sv
// Bundle of the calc_b_vector control, BRAM read and b write signals.
// Latency: n/a (wiring only).
// Backpressure: none; BRAM reads are fixed 1-cycle latency, b writes are fire-and-forget strobes.
// Ports (master = calc_b_vector side):
//   start_bvec/K_final in; q_addr/y_addr out, q_rdata/y_rdata in;
//   b_idx/b_val/b_we out; busy/done_bvec out.
interface calc_b_vector_if;
  import omp_pkg::*;

  logic                      start_bvec;
  logic [4:0]                K_final;
  logic [7:0]                q_addr;
  logic [LANES*DATA_W-1:0]   q_rdata;
  logic [3:0]                y_addr;
  logic [LANES*DATA_W-1:0]   y_rdata;
  logic [3:0]                b_idx;
  logic [DATA_W-1:0]         b_val;
  logic                      b_we;
  logic                      busy;
  logic                      done_bvec;

  modport master (
    input  start_bvec, K_final, q_rdata, y_rdata,
    output q_addr, y_addr, b_idx, b_val, b_we, busy, done_bvec
  );

  modport slave (
    output start_bvec, K_final, q_rdata, y_rdata,
    input  q_addr, y_addr, b_idx, b_val, b_we, busy, done_bvec
  );

endinterface

// File: rtl/dot4_lane.sv
// Combinational 4-lane signed multiply, per-lane >>> Q_FRAC, and sum.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: q_word_i/y_word_i = 4 packed 24-bit lanes (lane 0 in LSBs); sum_o = 48-bit signed sum.
module dot4_lane
  import omp_pkg::*;
(
  input  logic [LANES*DATA_W-1:0]  q_word_i,
  input  logic [LANES*DATA_W-1:0]  y_word_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  logic signed [ACC_W-1:0] shf [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DATA_W-1:0] qa;
    logic signed [DATA_W-1:0] ya;
    logic signed [ACC_W-1:0]  prod;

    assign qa   = q_word_i[l*DATA_W +: DATA_W];
    assign ya   = y_word_i[l*DATA_W +: DATA_W];
    // Sign-extend both operands so the 48-bit product is exact.
    assign prod = ACC_W'(qa) * ACC_W'(ya);
    // Rescale each lane back to Q.13 before summing (truncates toward -inf).
    assign shf[l] = prod >>> Q_FRAC;
  end

  always_comb begin
    sum_o = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_o = sum_o + shf[l];
    end
  end

endmodule

// File: rtl/calc_b_vector.sv
// Computes b[j] = sum_i Q[i][j]*y[i] for j < min(K_final,16), streaming Q/y from BRAM.
// Latency: first address 1 cycle after start, 18 cycles per column, done_bvec at 18*K+1 (1 when K=0).
// Backpressure: none; b_we strobes are unconditional and start_bvec is ignored while busy.
// Ports: clk, rst_n (async active-low); bus = calc_b_vector_if.master.
// Macro CALC_B_VECTOR_SAT_EN: when defined b_val saturates to 24 bits, otherwise it wraps.
module calc_b_vector
  import omp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  calc_b_vector_if.master   bus
);

  state_e                  state_q, state_d;
  logic [3:0]              j_q, j_d;
  logic [3:0]              w_q, w_d;
  logic [4:0]              k_q, k_d;
  logic [7:0]              q_addr_q, q_addr_d;
  logic [3:0]              y_addr_q, y_addr_d;
  logic [3:0]              b_idx_q, b_idx_d;
  logic [DATA_W-1:0]       b_val_q, b_val_d;
  logic                    b_we_q, b_we_d;
  logic                    done_q, done_d;
  logic                    busy_q;
  logic                    rd_vld_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] lane_sum;
  logic [DATA_W-1:0]       b_red;
  logic [4:0]              k_req;
  logic [4:0]              j_nxt;

  dot4_lane u_dot4_lane (
    .q_word_i (bus.q_rdata),
    .y_word_i (bus.y_rdata),
    .sum_o    (lane_sum)
  );

  assign k_req = (bus.K_final > 5'(K_MAX)) ? 5'(K_MAX) : bus.K_final;
  assign j_nxt = {1'b0, j_q} + 5'd1;

  // Accumulator: BRAM data lands one cycle after the address, so rd_vld_q marks
  // the cycles whose returned word belongs to the current column.
  always_comb begin
    acc_d = acc_q;
    if (state_q == S_READ && w_q == 4'd0) begin
      acc_d = '0;
    end else if (rd_vld_q) begin
      acc_d = acc_q + lane_sum;
    end
  end

`ifdef CALC_B_VECTOR_SAT_EN
  localparam logic signed [ACC_W-1:0] B_MAX = ACC_W'(24'h7FFFFF);
  localparam logic signed [ACC_W-1:0] B_MIN = ~B_MAX;  // -0x800000

  always_comb begin
    if (acc_d > B_MAX) begin
      b_red = 24'h7FFFFF;
    end else if (acc_d < B_MIN) begin
      b_red = 24'h800000;
    end else begin
      b_red = acc_d[DATA_W-1:0];
    end
  end
`else
  assign b_red = acc_d[DATA_W-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    w_d      = w_q;
    k_d      = k_q;
    q_addr_d = q_addr_q;
    y_addr_d = y_addr_q;
    b_idx_d  = b_idx_q;
    b_val_d  = b_val_q;
    b_we_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_bvec) begin
          k_d = k_req;
          j_d = 4'd0;
          w_d = 4'd0;
          if (k_req == 5'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_READ;
            q_addr_d = 8'd0;
            y_addr_d = 4'd0;
          end
        end
      end
      S_READ: begin
        if (w_q == 4'(N_WORDS-1)) begin
          state_d = S_DRAIN;
        end else begin
          w_d      = w_q + 4'd1;
          q_addr_d = {j_q, w_d};
          y_addr_d = w_d;
        end
      end
      S_DRAIN: begin
        // The last word is absorbed this cycle, so the result is taken from acc_d.
        state_d = S_WRITE;
        b_we_d  = 1'b1;
        b_idx_d = j_q;
        b_val_d = b_red;
      end
      S_WRITE: begin
        if (j_nxt < k_q) begin
          state_d  = S_READ;
          j_d      = j_q + 4'd1;
          w_d      = 4'd0;
          q_addr_d = {j_d, 4'd0};
          y_addr_d = 4'd0;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      j_q      <= '0;
      w_q      <= '0;
      k_q      <= '0;
      q_addr_q <= '0;
      y_addr_q <= '0;
      b_idx_q  <= '0;
      b_val_q  <= '0;
      b_we_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      w_q      <= w_d;
      k_q      <= k_d;
      q_addr_q <= q_addr_d;
      y_addr_q <= y_addr_d;
      b_idx_q  <= b_idx_d;
      b_val_q  <= b_val_d;
      b_we_q   <= b_we_d;
      done_q   <= done_d;
      busy_q   <= (state_d != S_IDLE);
      rd_vld_q <= (state_q == S_READ);
      acc_q    <= acc_d;
    end
  end

  assign bus.q_addr    = q_addr_q;
  assign bus.y_addr    = y_addr_q;
  assign bus.b_idx     = b_idx_q;
  assign bus.b_val     = b_val_q;
  assign bus.b_we      = b_we_q;
  assign bus.busy      = busy_q;
  assign bus.done_bvec = done_q;

endmodule

// File: tb/tb_calc_b_vector.sv
// Directed bench for calc_b_vector with 1-cycle-latency Q/y BRAM models.
module tb_calc_b_vector;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  calc_b_vector_if bus ();

  calc_b_vector u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [95:0] q_mem [0:255];
  logic [95:0] y_mem [0:15];

  always @(posedge clk) begin
    bus.q_rdata <= q_mem[bus.q_addr];
    bus.y_rdata <= y_mem[bus.y_addr];
  end

  // Results captured by run_job.
  int          wr_cnt;
  logic [3:0]  wr_idx [0:31];
  logic [23:0] wr_val [0:31];
  int          wr_cyc [0:31];
  int          done_cyc;
  logic        first_busy;
  logic [7:0]  first_qaddr;
  logic        busy_after;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] pack4(input logic [23:0] v);
    return {v, v, v, v};
  endfunction

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) q_mem[a] = '0;
    for (int a = 0; a < 16; a++)  y_mem[a] = '0;
  endtask

  // Pulse start, then watch up to max_cyc cycles (cycle 1 = first cycle after
  // the accepting edge). A second start pulse is driven at cycle 'repulse' (0 = none).
  task automatic run_job(input logic [4:0] kf, input int max_cyc, input int repulse);
    wr_cnt   = 0;
    done_cyc = -1;
    @(negedge clk);
    bus.K_final    = kf;
    bus.start_bvec = 1'b1;
    @(negedge clk);
    bus.start_bvec = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) begin
        first_busy  = bus.busy;
        first_qaddr = bus.q_addr;
      end
      if (bus.b_we && wr_cnt < 32) begin
        wr_idx[wr_cnt] = bus.b_idx;
        wr_val[wr_cnt] = bus.b_val;
        wr_cyc[wr_cnt] = c;
        wr_cnt++;
      end
      if (bus.done_bvec) begin
        done_cyc = c;
        break;
      end
      bus.start_bvec = (repulse != 0 && c == repulse);
    end
    bus.start_bvec = 1'b0;
    @(negedge clk);
    busy_after = bus.busy;
  endtask

  task automatic load_ramp();
    clear_mem();
    for (int w = 0; w < 16; w++) y_mem[w] = pack4(24'h002000);
    for (int j = 0; j < 16; j++)
      for (int w = 0; w < 16; w++)
        q_mem[j*16 + w] = pack4(24'((j + 1) * 24'h000080));
  endtask

  task automatic check_ramp(input string tag, input int k);
    chk({tag, " wr_cnt"}, 32'(wr_cnt), 32'(k));
    for (int j = 0; j < k && j < wr_cnt; j++) begin
      chk($sformatf("%s idx%0d", tag, j), 32'(wr_idx[j]), 32'(j));
      chk($sformatf("%s val%0d", tag, j), 32'(wr_val[j]), 32'((j + 1) * 24'h002000));
    end
    chk({tag, " done_cyc"}, 32'(done_cyc), 32'(18 * k + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int stray;
    logic [23:0] sat_exp;

    n_checks       = 0;
    n_errors       = 0;
    bus.start_bvec = 1'b0;
    bus.K_final    = '0;
    clear_mem();

    // Reset values
    rst_n = 1'b0;
    #23;
    chk("rst b_we",   32'(bus.b_we),      32'd0);
    chk("rst done",   32'(bus.done_bvec), 32'd0);
    chk("rst busy",   32'(bus.busy),      32'd0);
    chk("rst q_addr", 32'(bus.q_addr),    32'd0);
    chk("rst y_addr", 32'(bus.y_addr),    32'd0);
    chk("rst b_idx",  32'(bus.b_idx),     32'd0);
    chk("rst b_val",  32'(bus.b_val),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single entry: 1.0 * 9.0
    clear_mem();
    q_mem[0] = {72'd0, 24'h002000};
    y_mem[0] = {72'd0, 24'h012000};
    run_job(5'd1, 40, 0);
    chk("k1 busy c1",   32'(first_busy),  32'd1);
    chk("k1 qaddr c1",  32'(first_qaddr), 32'd0);
    chk("k1 wr_cnt",    32'(wr_cnt),      32'd1);
    chk("k1 idx",       32'(wr_idx[0]),   32'd0);
    chk("k1 val",       32'(wr_val[0]),   32'h012000);
    chk("k1 wr_cyc",    32'(wr_cyc[0]),   32'd18);
    chk("k1 done_cyc",  32'(done_cyc),    32'd19);
    chk("k1 busy after", 32'(busy_after), 32'd0);

    // Three columns, ramp data
    load_ramp();
    run_job(5'd3, 100, 0);
    check_ramp("k3", 3);

    // K = 0: immediate done, no writes
    run_job(5'd0, 10, 0);
    chk("k0 wr_cnt",   32'(wr_cnt),   32'd0);
    chk("k0 done_cyc", 32'(done_cyc), 32'd1);

    // K_final above 16 is clamped to 16
    run_job(5'd20, 320, 0);
    check_ramp("k20", 16);

    // Full-scale inputs: saturates or wraps to 0xFE0000 (2^39 - 2^17)
    clear_mem();
    for (int w = 0; w < 16; w++) begin
      q_mem[w] = pack4(24'h7FFFFF);
      y_mem[w] = pack4(24'h7FFFFF);
    end
`ifdef CALC_B_VECTOR_SAT_EN
    sat_exp = 24'h7FFFFF;
`else
    sat_exp = 24'hFE0000;
`endif
    run_job(5'd1, 40, 0);
    chk("full wr_cnt", 32'(wr_cnt),    32'd1);
    chk("full val",    32'(wr_val[0]), 32'(sat_exp));

    // Reset in the middle of column 1
    load_ramp();
    @(negedge clk);
    bus.K_final    = 5'd3;
    bus.start_bvec = 1'b1;
    @(negedge clk);
    bus.start_bvec = 1'b0;
    repeat (24) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid rst b_we",   32'(bus.b_we),      32'd0);
    chk("mid rst busy",   32'(bus.busy),      32'd0);
    chk("mid rst done",   32'(bus.done_bvec), 32'd0);
    chk("mid rst q_addr", 32'(bus.q_addr),    32'd0);
    chk("mid rst b_idx",  32'(bus.b_idx),     32'd0);
    chk("mid rst b_val",  32'(bus.b_val),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.b_we || bus.done_bvec || bus.busy) stray++;
    end
    chk("mid rst quiet", 32'(stray), 32'd0);
    run_job(5'd3, 100, 0);
    check_ramp("restart", 3);

    // Extra start while busy is ignored
    run_job(5'd3, 100, 10);
    check_ramp("repulse", 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
